// File: rtl/axi_rd_to_axis_if.sv
// axi_rd_to_axis_if: AXI4 read address/data channels plus the AXI-Stream output
// of the read-to-stream bridge.
interface axi_rd_to_axis_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 1
);
    logic [AXI_ID_WIDTH-1:0]     m_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [7:0]                  m_axi_arlen;
    logic [2:0]                  m_axi_arsize;
    logic [1:0]                  m_axi_arburst;
    logic                        m_axi_arvalid;
    logic                        m_axi_arready;
    logic [AXI_ID_WIDTH-1:0]     m_axi_rid;
    logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]                  m_axi_rresp;
    logic                        m_axi_rlast;
    logic                        m_axi_rvalid;
    logic                        m_axi_rready;
    logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata;
    logic [AXI_DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                        m_axis_tlast;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );
    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axi_rd_to_axis.sv
// axi_rd_to_axis: fetches a contiguous region with INCR bursts (max-length and
// 4 KB limited, one outstanding) and emits it as one AXI-Stream packet.
module axi_rd_to_axis #(
    parameter int AXI_DATA_WIDTH    = 64,
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int AXI_ID_WIDTH      = 1,
    parameter int AXI_MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    output logic                      sts_done,
    output logic                      sts_err,
    axi_rd_to_axis_if.master          bus
);
    localparam int BPB = AXI_DATA_WIDTH / 8;
    localparam int SZ = $clog2(BPB);
    localparam logic [AXI_ADDR_WIDTH-1:0] BPB_A = AXI_ADDR_WIDTH'(BPB);
    localparam logic [31:0] MAXB = 32'(AXI_MAX_BURST_LEN);

    typedef enum logic [1:0] {IDLE, ISSUE_AR, READ_DATA, DONE} state_t;
    state_t state, next;

    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH:0]        remaining;
    logic [8:0]                burst_cnt, beats;
    logic [12:0]               to_4k;
    logic [31:0]               lim_4k, lim;
    logic                      cmd_fire, ar_fire, r_fire, push, pop;
    logic [AXI_DATA_WIDTH:0]   mem [2];
    logic                      wp, rp;
    logic [1:0]                count;
    logic                      unused_rid;

    assign unused_rid = ^bus.m_axi_rid;

    // burst size is the tightest of: beats left, max burst, beats to the 4 KB line
    assign to_4k  = 13'd4096 - {1'b0, addr[11:0]};
    assign lim_4k = 32'(to_4k >> SZ);
    assign lim    = (32'(remaining) < lim_4k) ? 32'(remaining) : lim_4k;
    assign beats  = 9'((lim < MAXB) ? lim : MAXB);

    assign cmd_ready = state == IDLE;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ar_fire   = bus.m_axi_arvalid && bus.m_axi_arready;
    assign r_fire    = bus.m_axi_rvalid && bus.m_axi_rready;
    assign push      = r_fire;
    assign pop       = bus.m_axis_tvalid && bus.m_axis_tready;

    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_arsize  = 3'(SZ);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = state == ISSUE_AR;
    assign bus.m_axi_araddr  = (state == ISSUE_AR) ? addr : '0;
    assign bus.m_axi_arlen   = (state == ISSUE_AR) ? 8'(beats - 9'd1) : 8'd0;
    assign bus.m_axi_rready  = (state == READ_DATA) && (count != 2'd2);

    assign bus.m_axis_tvalid = count != 2'd0;
    assign bus.m_axis_tdata  = mem[rp][AXI_DATA_WIDTH:1];
    assign bus.m_axis_tlast  = bus.m_axis_tvalid && mem[rp][0];
    assign bus.m_axis_tkeep  = '1;

    always_ff @(posedge axi_aclk or negedge axi_aresetn)
        if (!axi_aresetn) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:      if (cmd_valid) next = (cmd_len != '0) ? ISSUE_AR : DONE;
            ISSUE_AR:  if (bus.m_axi_arready) next = READ_DATA;
            READ_DATA: if (r_fire && burst_cnt == 9'd1) next = (remaining != 1) ? ISSUE_AR : DONE;
            DONE:      if (count == 2'd0) next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // addr/remaining advance per beat; at each burst end they equal the per-burst update
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            addr      <= '0;
            remaining <= '0;
            burst_cnt <= '0;
            sts_err   <= 1'b0;
            sts_done  <= 1'b0;
        end else begin
            sts_done <= (state == DONE) && (count == 2'd0);
            if (cmd_fire) begin
                addr      <= cmd_addr;
                remaining <= {1'b0, cmd_len};
                sts_err   <= 1'b0;
            end
            if (ar_fire) burst_cnt <= beats;
            if (r_fire) begin
                addr      <= addr + BPB_A;
                remaining <= remaining - 1'b1;
                burst_cnt <= burst_cnt - 9'd1;
                if (bus.m_axi_rresp != 2'b00 || bus.m_axi_rlast != (burst_cnt == 9'd1)) sts_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            wp    <= wp ^ push;
            rp    <= rp ^ pop;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge axi_aclk)
        if (push) mem[wp] <= {bus.m_axi_rdata, remaining == 1};
endmodule

// File: tb/tb_axi_rd_to_axis.sv
// tb_axi_rd_to_axis: table-driven commands against a behavioural AXI slave,
// plus a mid-burst reset sequence.
module tb_axi_rd_to_axis;
    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        cmd_valid, cmd_ready, sts_done, sts_err;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    int          total = 0, bad = 0;
    int          err_beat = 0, bno = 0, left = 0;
    logic [31:0] cur;
    logic [39:0] ar_q[$];

    typedef struct {
        logic [31:0]      addr;
        int               len;
        int               eb;
        bit               bp;
        int               nb;
        logic [2:0][31:0] a;
        logic [2:0][7:0]  l;
        bit               ee;
    } vec_t;
    vec_t vecs[7];

    axi_rd_to_axis_if #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(1)) bus ();

    axi_rd_to_axis dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .sts_done(sts_done), .sts_err(sts_err), .bus(bus)
    );

    always #5 axi_aclk = ~axi_aclk;

    function automatic logic [63:0] f(input logic [31:0] a);
        return {a ^ 32'hC0DE_F00D, a};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    assign bus.m_axi_rid = '0;

    always @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            bus.m_axi_arready <= 1'b1;
            bus.m_axi_rvalid  <= 1'b0;
            bus.m_axi_rlast   <= 1'b0;
            left = 0;
        end else begin
            if (cmd_valid && cmd_ready) bno = 1;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                ar_q.push_back({bus.m_axi_araddr, bus.m_axi_arlen});
                cur = bus.m_axi_araddr;
                left = int'(bus.m_axi_arlen) + 1;
                bus.m_axi_arready <= 1'b0;
            end
            if ((bus.m_axi_arvalid && bus.m_axi_arready) || (bus.m_axi_rvalid && bus.m_axi_rready)) begin
                if (left > 0) begin
                    bus.m_axi_rvalid <= 1'b1;
                    bus.m_axi_rdata  <= f(cur);
                    bus.m_axi_rresp  <= (bno == err_beat) ? 2'b10 : 2'b00;
                    bus.m_axi_rlast  <= left == 1;
                    cur += 8;
                    left--;
                    bno++;
                end else begin
                    bus.m_axi_rvalid  <= 1'b0;
                    bus.m_axi_rlast   <= 1'b0;
                    bus.m_axi_arready <= 1'b1;
                end
            end
        end
    end

    task automatic run(input vec_t v);
        int k = 0, ndone = 0, done_cyc = 0, occ = 0;
        bit stall = 0;
        logic [64:0] prev = '0;
        err_beat = v.eb;
        ar_q.delete();
        @(negedge axi_aclk);
        cmd_addr = v.addr;
        cmd_len = 16'(v.len);
        cmd_valid = 1'b1;
        chk("cmd_ready", cmd_ready, 1);
        @(negedge axi_aclk);
        cmd_valid = 1'b0;
        chk("err_clear", sts_err, 0);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            bus.m_axis_tready = v.bp ? (!(cyc >= 6 && cyc < 16) && (cyc % 2 == 1)) : 1'b1;
            if (stall) begin
                chk("stall_valid", bus.m_axis_tvalid, 1);
                chk("stall_data", {bus.m_axis_tdata, bus.m_axis_tlast}, prev);
            end
            stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev = {bus.m_axis_tdata, bus.m_axis_tlast};
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                chk("tdata", bus.m_axis_tdata, f(v.addr + 32'(8 * k)));
                chk("tlast", bus.m_axis_tlast, k == v.len - 1);
                k++;
            end
            if (occ == 2) chk("rready_full", bus.m_axi_rready, 0);
            occ += int'(bus.m_axi_rvalid && bus.m_axi_rready) - int'(bus.m_axis_tvalid && bus.m_axis_tready);
            if (sts_done) begin
                if (ndone == 0) done_cyc = cyc;
                ndone++;
            end
            if (ndone > 0 && cyc > done_cyc + 3) break;
            @(negedge axi_aclk);
        end
        chk("beats", k, v.len);
        chk("done_pulses", ndone, 1);
        if (v.len == 0) chk("zero_done_lat", done_cyc, 2);
        chk("sts_err", sts_err, v.ee);
        chk("ar_count", ar_q.size(), v.nb);
        for (int i = 0; i < ar_q.size() && i < 3; i++) chk("ar_burst", ar_q[i], {v.a[i], v.l[i]});
    endtask

    task automatic rst_mid();
        int n = 0;
        err_beat = 0;
        bus.m_axis_tready = 1'b1;
        @(negedge axi_aclk);
        cmd_addr = 32'h8000;
        cmd_len = 16'd16;
        cmd_valid = 1'b1;
        @(negedge axi_aclk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) n++;
            @(negedge axi_aclk);
        end
        chk("pre_rst_beats", n, 4);
        axi_aresetn = 1'b0;
        #1;
        chk("rst_arvalid", bus.m_axi_arvalid, 0);
        chk("rst_rready", bus.m_axi_rready, 0);
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
    endtask

    initial begin
        axi_aresetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        chk("r_cmd_ready", cmd_ready, 1);
        chk("r_arvalid", bus.m_axi_arvalid, 0);
        chk("r_rready", bus.m_axi_rready, 0);
        chk("r_tvalid", bus.m_axis_tvalid, 0);
        chk("r_tlast", bus.m_axis_tlast, 0);
        chk("r_done", sts_done, 0);
        chk("r_err", sts_err, 0);
        chk("r_araddr", bus.m_axi_araddr, 0);
        chk("r_arlen", bus.m_axi_arlen, 0);
        axi_aresetn = 1'b1;
        vecs[0] = '{32'h1000, 40, 0, 0, 3, {32'h1100, 32'h1080, 32'h1000}, {8'd7, 8'd15, 8'd15}, 0};
        vecs[1] = '{32'h0FF0, 4, 0, 0, 2, {32'h0, 32'h1000, 32'h0FF0}, {8'd0, 8'd1, 8'd1}, 0};
        vecs[2] = '{32'h2000, 8, 0, 1, 1, {32'h0, 32'h0, 32'h2000}, {8'd0, 8'd0, 8'd7}, 0};
        vecs[3] = '{32'h3000, 4, 3, 0, 1, {32'h0, 32'h0, 32'h3000}, {8'd0, 8'd0, 8'd3}, 1};
        vecs[4] = '{32'h4000, 0, 0, 0, 0, {32'h0, 32'h0, 32'h0}, {8'd0, 8'd0, 8'd0}, 0};
        vecs[5] = '{32'h5F80, 20, 0, 0, 2, {32'h0, 32'h6000, 32'h5F80}, {8'd0, 8'd3, 8'd15}, 0};
        vecs[6] = '{32'h0FF8, 1, 0, 0, 1, {32'h0, 32'h0, 32'h0FF8}, {8'd0, 8'd0, 8'd0}, 0};
        for (int i = 0; i < 7; i++) run(vecs[i]);
        rst_mid();
        run(vecs[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_rd_to_axis.md
Name: axi_rd_to_axis

Overview:
- AXI4 read master that fetches a contiguous memory region and emits it as an AXI-Stream packet.
- Counterpart of the stream-to-AXI write path; sits between a DMA/descriptor controller and a downstream stream consumer.
- One command yields one packet. The command is split into INCR bursts limited by AXI_MAX_BURST_LEN and 4 KB boundaries.
- Data width is identical on both sides; no width conversion.

Parameters:
- AXI_DATA_WIDTH, 64, AXI R data width and AXIS tdata width (power of 2, ≥ 8).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_ID_WIDTH, 1, arid/rid width; arid is driven constant 0.
- AXI_MAX_BURST_LEN, 16, maximum beats per burst (1..256).
- LEN_WIDTH, 16, width of command beat count.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  async active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address, aligned to AXI_DATA_WIDTH/8
- cmd_len  in  LEN_WIDTH  number of beats; 0 means no transfer
- sts_done  out  1  one-cycle pulse when a command completes
- sts_err  out  1  sticky error; cleared on next command accept
- m_axi_arid  out  AXI_ID_WIDTH  constant 0
- m_axi_araddr  out  AXI_ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  log2(AXI_DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rid  in  AXI_ID_WIDTH  ignored
- m_axi_rdata  in  AXI_DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axis_tdata  out  AXI_DATA_WIDTH
- m_axis_tkeep  out  AXI_DATA_WIDTH/8  all ones
- m_axis_tlast  out  1  last beat of command
- m_axis_tvalid  out  1
- m_axis_tready  in  1

Behaviour:
- Reset: asynchronous on axi_aresetn low, clock axi_aclk. All state returns to IDLE and the FIFO is emptied. Output reset values:
  - cmd_ready = 1
  - arvalid = 0, rready = 0, tvalid = 0, tlast = 0
  - sts_done = 0, sts_err = 0
  - araddr = 0, arlen = 0
- Reset mid-operation abandons the transfer with no flush. The bench must also reset the slave.
- FSM states: IDLE, ISSUE_AR, READ_DATA, DONE.
  - IDLE: cmd_ready = 1. On accept, latch addr and remaining = cmd_len, clear sts_err. Go to ISSUE_AR if cmd_len != 0, else DONE.
  - ISSUE_AR: burst beats = min(remaining, AXI_MAX_BURST_LEN, (4096 - addr[11:0]) / bytes_per_beat). Drive arvalid with araddr and arlen = beats-1. Hold all AR signals stable until arready. On the handshake go to READ_DATA.
  - READ_DATA: rready = !fifo_full. Each accepted R beat is pushed to the FIFO and decrements the burst counter.
    - On the final counted beat: addr += beats*bytes_per_beat, remaining -= beats.
    - Next state is ISSUE_AR if remaining != 0, else DONE.
  - DONE: wait until the FIFO is empty (last beat consumed). Then pulse sts_done for 1 cycle and return to IDLE. cmd_ready is 0 in every state except IDLE.
- Only one outstanding burst; arvalid is never asserted while an R beat of the current burst is pending.
- Output buffer: 2-entry FIFO storing {data, last}.
  - An R beat accepted at cycle N is visible on tdata at N+1.
  - Full throughput (1 beat/cycle) is sustained while tready = 1.
  - Simultaneous push and pop when full is not permitted; rready already excludes it.
  - tvalid/tdata/tlast stay stable while tready = 0.
- tlast is set on the beat where remaining reaches 0.
- Errors set sts_err (sticky until next accept). Data is still forwarded and the beat count is still honoured. Error conditions:
  - rresp != OKAY on any beat.
  - rlast disagreeing with the beat counter (rlast early or missing on the final beat).
- Width rules: remaining and beat math use LEN_WIDTH+1 bits; address addition wraps modulo 2^AXI_ADDR_WIDTH.

Test Plan:
- Basic split: addr 0x1000, len 40, 64-bit data, MAX 16 → AR bursts (0x1000, arlen 15), (0x1080, 15), (0x1100, 7). 40 stream beats in order, tlast only on beat 40, sts_done one pulse.
- 4 KB crossing: addr 0x0FF0, len 4 → bursts (0x0FF0, arlen 1), (0x1000, arlen 1). 4 beats out, tlast on beat 4.
- Backpressure: len 8, tready toggled 1/0 every cycle and also held low 10 cycles → rready drops once the FIFO holds 2 beats, no beat lost or duplicated, tdata stable while stalled.
- Error: len 4, slave returns SLVERR on beat 3 → all 4 beats still emitted, sts_err = 1 after beat 3, cleared when the next command is accepted.
- Zero length: cmd_len 0 → no arvalid, sts_done pulses 2 cycles after accept, no tvalid.
- Reset mid-burst: assert axi_aresetn low during beat 5 of 16 → arvalid/rready/tvalid go 0 immediately, cmd_ready = 1 after release, a new command runs correctly.
